morse_sequencer: RTL and testbench
==================================

Name: morse_sequencer

Overview:
Controller that plays a queued message of up to MAX_LETTERS Morse letters (S..Z, 3-bit codes) on a single LED output. It owns the letter-pattern lookup, the bit-rate tick divider and the serialising shift register, and sequences letters with inter-letter gaps. A start/busy/done handshake lets a top-level wrapper (switches and keys on the board) launch and abort messages.

Parameters:
TICK_DIV, 25000000, clock cycles per Morse unit (0.5 s at 50 MHz); legal range is 2 or more.
GAP_TICKS, 3, units of LED-off inserted after every letter, including the last; legal range is 1 or more.
MAX_LETTERS, 4, queue depth in letters.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request to play a message; sampled only in IDLE.
abort  input  1  synchronous cancel of the current message.
letters  input  3*MAX_LETTERS  letter codes; letters[2:0] plays first.
count  input  3  number of letters to play (1..MAX_LETTERS).
busy  output  1  high while a message is playing.
done  output  1  one-cycle pulse when a message completes normally.
led  output  1  serial Morse output.
letter_idx  output  2  index of the letter currently playing.

Behaviour:
- Reset is asynchronous on reset_n=0. Reset values: state=IDLE; busy=0; done=0; led=0; letter_idx=0; divider, shift register, bit and gap counters all 0.
- Pattern table, LSB is sent first; each entry is given as code: binary (bit length):
  - 000: 10101 (5)
  - 001: 111 (3)
  - 010: 1110101 (7)
  - 011: 111010101 (9)
  - 100: 111011101 (9)
  - 101: 11101010111 (11)
  - 110: 1110111010111 (13)
  - 111: 1110101110111 (13)
  - The shift register is 14 bits wide and zero-extended.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE, start=1 with 1<=count<=MAX_LETTERS:
  - Latch letters and count, set letter_idx=0, load the pattern and length of letter 0, clear the divider.
  - Enter SHIFT next cycle; busy=1 from that cycle.
- IDLE, start=1 with count=0 or count>MAX_LETTERS: request ignored; stay in IDLE; busy stays 0.
- start while not in IDLE is ignored. Latched letters and count are unaffected by input changes after acceptance.
- Tick: the divider counts 0..TICK_DIV-1 in SHIFT and GAP. tick=1 in the cycle the divider equals TICK_DIV-1; the divider then wraps to 0.
- Consequently every LED bit and every gap unit lasts exactly TICK_DIV cycles.
- SHIFT:
  - led = shreg[0].
  - On tick with bits_left>1: shreg shifts right by 1 (zero fill); bits_left decrements.
  - On tick with bits_left=1: enter GAP with gap_cnt=GAP_TICKS.
- GAP:
  - led=0.
  - On tick with gap_cnt>1: gap_cnt decrements.
  - On tick with gap_cnt=1 and letter_idx+1<count: increment letter_idx, load the next pattern and length, enter SHIFT.
  - On tick with gap_cnt=1 otherwise: enter DONE.
- DONE: lasts one cycle; done=1, busy=0, led=0. Then IDLE. A start during DONE is ignored.
- Latency: for a message of total pattern bits B and count N, done asserts (B+N*GAP_TICKS)*TICK_DIV+1 cycles after the start cycle.
- abort=1 in SHIFT, GAP or DONE: next cycle state=IDLE, busy=0, led=0, letter_idx=0, no done pulse.
- abort has priority over tick in the same cycle. abort in IDLE has no effect, and has priority over a simultaneous start.
- Reset mid-message: immediate return to reset values; no done pulse.
- busy and done are never high together.

Test Plan:
1. TICK_DIV=4, GAP_TICKS=3; start at cycle 0 with count=1, letters[2:0]=000 -> busy=1 in cycles 1..32; led high in cycles 1-4, 9-12 and 17-20, low elsewhere; done pulses at cycle 33 only.
2. count=2, letters[2:0]=001, letters[5:3]=000 -> led=111 for 12 cycles then 12 cycles of gap; letter_idx goes 0 to 1 at cycle 25; pattern 10101 follows; done at cycle 1+(3+5+6)*4=57.
3. count=4, codes 110,110,110,110 -> four 13-bit patterns; done at cycle (52+12)*4+1=257; letter_idx takes 0,1,2,3 in order.
4. count=0, and separately count=5, each with start=1 -> busy stays 0, no done pulse, led stays 0.
5. abort asserted at cycle 10 of a 111 message -> busy=0, led=0, letter_idx=0 at cycle 11; no done pulse; a new start at cycle 12 is accepted.
6. reset_n low at cycle 7 mid-SHIFT -> all outputs 0 asynchronously; start at cycle 2 while busy -> ignored, timing identical to scenario 1.

Source files
------------

// File: rtl/morse_sequencer_if.sv
// Message bus between the board wrapper and the Morse sequencer.
// The wrapper (master) launches and cancels messages.
// The sequencer (slave) reports progress and drives the LED.
interface morse_sequencer_if #(
  parameter int MAX_LETTERS = 4
);
  logic                     start;
  logic                     abort;
  logic [3*MAX_LETTERS-1:0] letters;
  logic [2:0]               count;
  logic                     busy;
  logic                     done;
  logic                     led;
  logic [1:0]               letter_idx;

  modport master (
    output start, abort, letters, count,
    input  busy, done, led, letter_idx
  );

  modport slave (
    input  start, abort, letters, count,
    output busy, done, led, letter_idx
  );
endinterface

// File: rtl/morse_sequencer.sv
// Morse message player. It plays up to MAX_LETTERS queued letters (S..Z) on one LED.
// Each LED bit and each gap unit lasts TICK_DIV clocks.
// GAP_TICKS units of dark follow every letter, including the last one.
module morse_sequencer #(
  parameter int TICK_DIV    = 25000000,
  parameter int GAP_TICKS   = 3,
  parameter int MAX_LETTERS = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  morse_sequencer_if.slave bus
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TICKS);
  localparam logic [2:0]       MAX_CNT  = 3'(MAX_LETTERS);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t                   state_q;
  logic [3*MAX_LETTERS-1:0] letters_q;
  logic [2:0]               count_q;
  logic [1:0]               letter_idx_q;
  logic [13:0]              shreg_q;
  logic [3:0]               bits_left_q;
  logic [GAP_W-1:0]         gap_cnt_q;
  logic [DIV_W-1:0]         div_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     led_q;

  logic [1:0]  next_idx;
  logic [2:0]  load_code_d;
  logic [13:0] pattern_d;
  logic [3:0]  length_d;
  logic        tick;
  logic        start_ok;
  logic        more_letters;

  assign next_idx     = letter_idx_q + 2'd1;
  assign tick         = (div_q == DIV_LAST);
  assign more_letters = (({1'b0, letter_idx_q} + 3'd1) < count_q);
  assign start_ok     = bus.start && !bus.abort && (bus.count != 3'd0) &&
                        (bus.count <= MAX_CNT);

  // Pick the letter code to load: letter 0 of the incoming request when idle, otherwise the next latched letter
  always_comb begin
    load_code_d = bus.letters[2:0];
    if (state_q != IDLE) begin
      load_code_d = 3'd0;
      for (int i = 0; i < MAX_LETTERS; i++) begin
        if (int'(next_idx) == i) load_code_d = letters_q[3*i +: 3];
      end
    end
  end

  // Letter pattern table; the LSB goes out first and unused upper bits stay zero
  always_comb begin
    pattern_d = 14'd0;
    length_d  = 4'd0;
    case (load_code_d)
      3'b000: begin pattern_d = 14'b00000000010101; length_d = 4'd5;  end
      3'b001: begin pattern_d = 14'b00000000000111; length_d = 4'd3;  end
      3'b010: begin pattern_d = 14'b00000001110101; length_d = 4'd7;  end
      3'b011: begin pattern_d = 14'b00000111010101; length_d = 4'd9;  end
      3'b100: begin pattern_d = 14'b00000111011101; length_d = 4'd9;  end
      3'b101: begin pattern_d = 14'b00011101010111; length_d = 4'd11; end
      3'b110: begin pattern_d = 14'b01110111010111; length_d = 4'd13; end
      3'b111: begin pattern_d = 14'b01110101110111; length_d = 4'd13; end
      default: begin pattern_d = 14'd0; length_d = 4'd0; end
    endcase
  end

  // Sequencer FSM. It owns the divider, the shift register, the counters and the registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      letters_q    <= '0;
      count_q      <= 3'd0;
      letter_idx_q <= 2'd0;
      shreg_q      <= 14'd0;
      bits_left_q  <= 4'd0;
      gap_cnt_q    <= '0;
      div_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      led_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            letters_q    <= bus.letters;
            count_q      <= bus.count;
            letter_idx_q <= 2'd0;
            shreg_q      <= pattern_d;
            bits_left_q  <= length_d;
            div_q        <= '0;
            led_q        <= pattern_d[0];
            busy_q       <= 1'b1;
            state_q      <= SHIFT;
          end
        end

        SHIFT: begin
          if (bus.abort) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            led_q        <= 1'b0;
            letter_idx_q <= 2'd0;
            div_q        <= '0;
          end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
              if (bits_left_q > 4'd1) begin
                shreg_q     <= {1'b0, shreg_q[13:1]};
                bits_left_q <= bits_left_q - 4'd1;
                led_q       <= shreg_q[1];
              end else begin
                gap_cnt_q <= GAP_LOAD;
                led_q     <= 1'b0;
                state_q   <= GAP;
              end
            end
          end
        end

        GAP: begin
          if (bus.abort) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            led_q        <= 1'b0;
            letter_idx_q <= 2'd0;
            div_q        <= '0;
          end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
              if (gap_cnt_q > GAP_W'(1)) begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
              end else if (more_letters) begin
                letter_idx_q <= next_idx;
                shreg_q      <= pattern_d;
                bits_left_q  <= length_d;
                led_q        <= pattern_d[0];
                state_q      <= SHIFT;
              end else begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end
          end
        end

        DONE: begin
          state_q      <= IDLE;
          letter_idx_q <= 2'd0;
          div_q        <= '0;
          led_q        <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.led        = led_q;
  assign bus.letter_idx = letter_idx_q;

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed testbench for morse_sequencer with a short tick and a 3-unit gap.
// Expected LED waveforms are written out by hand, one character per Morse unit.
module tb_morse_sequencer;

  localparam int TICK_DIV    = 4;
  localparam int GAP_TICKS   = 3;
  localparam int MAX_LETTERS = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  // Free-running 10 ns clock
  always #5 clock = ~clock;

  morse_sequencer_if #(.MAX_LETTERS(MAX_LETTERS)) bus();

  morse_sequencer #(
    .TICK_DIV   (TICK_DIV),
    .GAP_TICKS  (GAP_TICKS),
    .MAX_LETTERS(MAX_LETTERS)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [11:0] l,
                               input logic [2:0] c);
    bus.start   = s;
    bus.abort   = a;
    bus.letters = l;
    bus.count   = c;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " busy"}, int'(bus.busy), 0);
    checkOutput({tag, " done"}, int'(bus.done), 0);
    checkOutput({tag, " led"},  int'(bus.led), 0);
    checkOutput({tag, " idx"},  int'(bus.letter_idx), 0);
  endtask

  // Start a message in the current cycle (cycle 0) and check every cycle up to just past done.
  // A second start is injected at cycle restartAt with different letters.
  // It must be ignored and must not disturb the message.
  task automatic runMessage(input string tag, input logic [11:0] l, input logic [2:0] c,
                            input string units, input string idxs, input int restartAt);
    int n;
    n = units.len();
    applyStimulus(1'b1, 1'b0, l, c);
    for (int cyc = 1; cyc <= n*TICK_DIV + 2; cyc++) begin
      nextCycle();
      if (cyc == 1) applyStimulus(1'b0, 1'b0, l, c);
      if (cyc <= n*TICK_DIV) begin
        int u;
        u = (cyc - 1) / TICK_DIV;
        checkOutput($sformatf("%s c%0d led", tag, cyc), int'(bus.led), int'(units[u] == "1"));
        checkOutput($sformatf("%s c%0d busy", tag, cyc), int'(bus.busy), 1);
        checkOutput($sformatf("%s c%0d done", tag, cyc), int'(bus.done), 0);
        checkOutput($sformatf("%s c%0d idx", tag, cyc), int'(bus.letter_idx),
                    int'(idxs[u]) - 48);
      end else if (cyc == n*TICK_DIV + 1) begin
        checkOutput($sformatf("%s c%0d done", tag, cyc), int'(bus.done), 1);
        checkOutput($sformatf("%s c%0d busy", tag, cyc), int'(bus.busy), 0);
        checkOutput($sformatf("%s c%0d led", tag, cyc), int'(bus.led), 0);
      end else begin
        checkOutput($sformatf("%s c%0d done", tag, cyc), int'(bus.done), 0);
        checkOutput($sformatf("%s c%0d busy", tag, cyc), int'(bus.busy), 0);
      end
      if (cyc == restartAt)     applyStimulus(1'b1, 1'b0, 12'hFFF, 3'd1);
      if (cyc == restartAt + 1) applyStimulus(1'b0, 1'b0, l, c);
    end
  endtask

  // Directed scenarios
  initial begin
    string p110;
    string p111;
    applyStimulus(1'b0, 1'b0, 12'd0, 3'd0);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    checkQuiet("reset");
    #2 reset_n = 1'b1;
    nextCycle();

    // Letter 000, a single letter
    runMessage("s1", 12'b000_000_000_000, 3'd1, "10101000", "00000000", -1);

    // Letters 001 then 000
    runMessage("s2", 12'b000_000_000_001, 3'd2,
               "11100010101000", "00000011111111", -1);

    // Four letters 110
    p110 = "1110101110111000";
    runMessage("s3", 12'b110_110_110_110, 3'd4, {p110, p110, p110, p110},
               {"0000000000000000", "1111111111111111",
                "2222222222222222", "3333333333333333"}, -1);

    // A start while busy is ignored; timing is identical to the single-letter case
    runMessage("s6b", 12'b000_000_000_000, 3'd1, "10101000", "00000000", 2);

    // Illegal counts are ignored
    applyStimulus(1'b1, 1'b0, 12'b001, 3'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 12'b001, 3'd0);
    for (int i = 0; i < 6; i++) begin
      checkQuiet($sformatf("cnt0 c%0d", i + 1));
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 12'b001, 3'd5);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 12'b001, 3'd5);
    for (int i = 0; i < 6; i++) begin
      checkQuiet($sformatf("cnt5 c%0d", i + 1));
      nextCycle();
    end

    // Abort in IDLE wins over a simultaneous start
    applyStimulus(1'b1, 1'b1, 12'b001, 3'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 12'b001, 3'd1);
    for (int i = 0; i < 4; i++) begin
      checkQuiet($sformatf("idleabort c%0d", i + 1));
      nextCycle();
    end

    // Abort at cycle 10 of a 111 message, then a fresh start at cycle 12
    p111 = "1110111010111";
    applyStimulus(1'b1, 1'b0, 12'b111, 3'd1);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      nextCycle();
      if (cyc == 1) applyStimulus(1'b0, 1'b0, 12'b111, 3'd1);
      checkOutput($sformatf("s5 c%0d led", cyc), int'(bus.led),
                  int'(p111[(cyc - 1) / TICK_DIV] == "1"));
      checkOutput($sformatf("s5 c%0d busy", cyc), int'(bus.busy), 1);
    end
    applyStimulus(1'b0, 1'b1, 12'b111, 3'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 12'b111, 3'd1);
    checkQuiet("s5 c11");
    nextCycle();
    checkQuiet("s5 c12");
    runMessage("s5restart", 12'b000_000_000_000, 3'd1, "10101000", "00000000", -1);

    // Reset in the middle of SHIFT clears the outputs without waiting for a clock edge
    applyStimulus(1'b1, 1'b0, 12'b000_000_000_001, 3'd2);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      nextCycle();
      if (cyc == 1) applyStimulus(1'b0, 1'b0, 12'b000_000_000_001, 3'd2);
    end
    checkOutput("s6 c7 led", int'(bus.led), 1);
    checkOutput("s6 c7 busy", int'(bus.busy), 1);
    #2 reset_n = 1'b0;
    #1;
    checkQuiet("s6 async");
    nextCycle();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      nextCycle();
      checkOutput($sformatf("s6 post c%0d done", i), int'(bus.done), 0);
      checkOutput($sformatf("s6 post c%0d busy", i), int'(bus.busy), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
